// File: rtl/rom_arbiter.sv
// Arbitrates the instruction ROM read port between ibus (fetch) and dbus (constant loads)
// and routes each response back through a ROM_LATENCY-deep tag pipeline. Define ROM_ARB_ROUND_ROBIN_EN for round-robin.
module rom_arbiter #(
    parameter int unsigned ROM_ADDR_WIDTH = 12,
    parameter int unsigned ROM_LATENCY    = 1,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [ROM_ADDR_WIDTH-1:0] i_addr,
    input  logic                      i_flush,
    output logic                      i_gnt,
    output logic                      i_rvalid,
    output logic [31:0]               i_rdata,
    input  logic                      d_req,
    input  logic [ROM_ADDR_WIDTH-1:0] d_addr,
    output logic                      d_gnt,
    output logic                      d_rvalid,
    output logic [31:0]               d_rdata,
    output logic                      rom_rd_en,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]               rom_rd_data
);

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    logic   [ROM_LATENCY-1:0] tag_vld;
    owner_t                   tag_own [ROM_LATENCY];
    logic                     d_wins;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    owner_t last_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= OWN_D;
        end else if (i_gnt) begin
            last_gnt <= OWN_I;
        end else if (d_gnt) begin
            last_gnt <= OWN_D;
        end
    end

    assign d_wins = (last_gnt == OWN_I);
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    // Counts consecutive cycles dbus lost to ibus; saturates so dbus keeps priority until served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (d_gnt || !d_req) begin
            starve_cnt <= '0;
        end else if (i_gnt && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign d_wins = (starve_cnt == STARVE_MAX);
`endif

    always_comb begin
        i_gnt     = i_req & ~(d_req & d_wins);
        d_gnt     = d_req & ~(i_req & ~d_wins);
        rom_rd_en = i_gnt | d_gnt;
        rom_addr  = '0;
        if (i_gnt) begin
            rom_addr = i_addr;
        end else if (d_gnt) begin
            rom_addr = d_addr;
        end
    end

    // Flush masks ibus entries as they shift; the entry loaded this edge is never masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            for (int unsigned k = 0; k < ROM_LATENCY; k++) begin
                tag_own[k] <= OWN_I;
            end
        end else begin
            tag_vld[0] <= rom_rd_en;
            tag_own[0] <= d_gnt ? OWN_D : OWN_I;
            for (int unsigned k = 1; k < ROM_LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1] & ~(i_flush & (tag_own[k-1] == OWN_I));
                tag_own[k] <= tag_own[k-1];
            end
        end
    end

    always_comb begin
        i_rvalid = tag_vld[ROM_LATENCY-1] & (tag_own[ROM_LATENCY-1] == OWN_I);
        d_rvalid = tag_vld[ROM_LATENCY-1] & (tag_own[ROM_LATENCY-1] == OWN_D);
        i_rdata  = i_rvalid ? rom_rd_data : '0;
        d_rdata  = d_rvalid ? rom_rd_data : '0;
    end

endmodule
